// File: rtl/wb_mem_arbiter_if.sv
// Bus bundle for wb_mem_arbiter.
//   iwb_*  : instruction master (read-only Wishbone classic)
//   dwb_*  : data master (read/write Wishbone classic)
//   m_*    : shared port toward the unified memory slave
//   grant_o: {d_granted, i_granted} debug view
//   timeout_o: sticky watchdog-fired flag
// Modport 'slave' is the arbiter's view; 'master' is the environment's view.
interface wb_mem_arbiter_if;
    logic [31:0] iwb_adr_i;
    logic        iwb_cyc_i;
    logic        iwb_stb_i;
    logic [31:0] iwb_dat_o;
    logic        iwb_ack_o;
    logic        iwb_err_o;

    logic [31:0] dwb_adr_i;
    logic [31:0] dwb_dat_i;
    logic        dwb_we_i;
    logic [3:0]  dwb_sel_i;
    logic        dwb_cyc_i;
    logic        dwb_stb_i;
    logic [31:0] dwb_dat_o;
    logic        dwb_ack_o;
    logic        dwb_err_o;

    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic [31:0] m_dat_i;
    logic        m_ack_i;
    logic        m_err_i;

    logic [1:0]  grant_o;
    logic        timeout_o;

    modport slave (
        input  iwb_adr_i, iwb_cyc_i, iwb_stb_i,
        output iwb_dat_o, iwb_ack_o, iwb_err_o,
        input  dwb_adr_i, dwb_dat_i, dwb_we_i, dwb_sel_i, dwb_cyc_i, dwb_stb_i,
        output dwb_dat_o, dwb_ack_o, dwb_err_o,
        output m_adr_o, m_dat_o, m_we_o, m_sel_o, m_cyc_o, m_stb_o,
        input  m_dat_i, m_ack_i, m_err_i,
        output grant_o, timeout_o
    );

    modport master (
        output iwb_adr_i, iwb_cyc_i, iwb_stb_i,
        input  iwb_dat_o, iwb_ack_o, iwb_err_o,
        output dwb_adr_i, dwb_dat_i, dwb_we_i, dwb_sel_i, dwb_cyc_i, dwb_stb_i,
        input  dwb_dat_o, dwb_ack_o, dwb_err_o,
        input  m_adr_o, m_dat_o, m_we_o, m_sel_o, m_cyc_o, m_stb_o,
        output m_dat_i, m_ack_i, m_err_i,
        input  grant_o, timeout_o
    );
endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone classic arbiter sharing one unified memory port between
// the instruction bus (iwb) and data bus (dwb). Round-robin under contention,
// grant held for a whole transaction, per-transaction watchdog.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : wb_mem_arbiter_if.slave (iwb_*, dwb_*, m_*, grant_o, timeout_o)
// Parameters:
//   TIMEOUT_CYCLES : BUSY cycles without a response before a watchdog error (2..65535)
//   CNT_W          : watchdog counter width, must hold TIMEOUT_CYCLES
module wb_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wb_mem_arbiter_if.slave       bus
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t           state_q, state_d;
    logic             last_d_q, last_d_d;   // 1: last grant went to dwb
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic i_req, d_req;
    logic busy, sel_d;
    logic x_cyc, x_stb;
    logic x_ack, x_err, wd_fire;

    assign i_req = bus.iwb_cyc_i & bus.iwb_stb_i;
    assign d_req = bus.dwb_cyc_i & bus.dwb_stb_i;
    assign busy  = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign sel_d = (state_q == BUSY_D);
    assign x_cyc = sel_d ? bus.dwb_cyc_i : bus.iwb_cyc_i;
    assign x_stb = sel_d ? bus.dwb_stb_i : bus.iwb_stb_i;

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        x_ack     = 1'b0;
        x_err     = 1'b0;
        wd_fire   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // On contention the master that did not win last time goes.
                if (d_req && (!i_req || !last_d_q)) begin
                    state_d  = BUSY_D;
                    last_d_d = 1'b1;
                    cnt_d    = '0;
                end else if (i_req) begin
                    state_d  = BUSY_I;
                    last_d_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                // Response beats abort, abort beats the watchdog.
                if (bus.m_ack_i) begin
                    x_ack   = 1'b1;
                    state_d = IDLE;
                end else if (bus.m_err_i) begin
                    x_err   = 1'b1;
                    state_d = IDLE;
                end else if (!x_cyc) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    wd_fire   = 1'b1;
                    x_err     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Memory-side mux; the instruction path is a fixed full-word read.
    assign bus.m_adr_o = !busy ? 32'h0 : (sel_d ? bus.dwb_adr_i : bus.iwb_adr_i);
    assign bus.m_dat_o = (busy && sel_d) ? bus.dwb_dat_i : 32'h0;
    assign bus.m_we_o  = busy & sel_d & bus.dwb_we_i;
    assign bus.m_sel_o = !busy ? 4'h0 : (sel_d ? bus.dwb_sel_i : 4'hF);
    assign bus.m_cyc_o = busy & x_cyc & ~wd_fire;
    assign bus.m_stb_o = busy & x_stb & ~wd_fire;

    assign bus.iwb_ack_o = x_ack & ~sel_d;
    assign bus.iwb_err_o = x_err & ~sel_d;
    assign bus.dwb_ack_o = x_ack &  sel_d;
    assign bus.dwb_err_o = x_err &  sel_d;
    assign bus.iwb_dat_o = bus.m_dat_i;
    assign bus.dwb_dat_o = bus.m_dat_i;

    assign bus.grant_o   = {state_q == BUSY_D, state_q == BUSY_I};
    assign bus.timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter (TIMEOUT_CYCLES=8). Inputs change #1 after
// the rising edge; outputs are sampled #1 later, well away from the edge.
module tb_wb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    wb_mem_arbiter_if bus();

    wb_mem_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {grant[1:0], m_cyc, m_stb, iwb_ack, iwb_err, dwb_ack, dwb_err, timeout}
    function automatic logic [8:0] ctl();
        return {bus.grant_o, bus.m_cyc_o, bus.m_stb_o, bus.iwb_ack_o, bus.iwb_err_o,
                bus.dwb_ack_o, bus.dwb_err_o, bus.timeout_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = ctl();
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: ctl observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ireq(input logic on, input logic [31:0] adr);
        bus.iwb_cyc_i = on;
        bus.iwb_stb_i = on;
        bus.iwb_adr_i = adr;
    endtask

    task automatic dreq(input logic on, input logic [31:0] adr, input logic we,
                        input logic [31:0] dat, input logic [3:0] sel);
        bus.dwb_cyc_i = on;
        bus.dwb_stb_i = on;
        bus.dwb_adr_i = adr;
        bus.dwb_we_i  = we;
        bus.dwb_dat_i = dat;
        bus.dwb_sel_i = sel;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        ireq(1'b0, 32'h0);
        dreq(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        bus.m_dat_i = 32'hDEADBEEF;
        bus.m_ack_i = 1'b0;
        bus.m_err_i = 1'b0;

        // ---- reset state
        step();
        step();
        chk_ctl("reset_ctl", 9'b00_00_00_00_0);
        chk32("reset_idat", bus.iwb_dat_o, 32'hDEADBEEF);
        chk32("reset_ddat", bus.dwb_dat_o, 32'hDEADBEEF);
        chk32("reset_madr", bus.m_adr_o, 32'h0);
        rst_n = 1'b1;
        step();

        // ---- single instruction fetch
        ireq(1'b1, 32'h100);
        bus.m_dat_i = 32'h00000013;
        settle();
        chk_ctl("fetch_c0", 9'b00_00_00_00_0);
        step();
        chk_ctl("fetch_c1", 9'b01_11_00_00_0);
        chk32("fetch_adr", bus.m_adr_o, 32'h100);
        chk32("fetch_wesel", {27'h0, bus.m_we_o, bus.m_sel_o}, {27'h0, 5'b0_1111});
        chk32("fetch_mdat", bus.m_dat_o, 32'h0);
        step();
        bus.m_ack_i = 1'b1;
        settle();
        chk_ctl("fetch_ack", 9'b01_11_10_00_0);
        chk32("fetch_rdat", bus.iwb_dat_o, 32'h00000013);
        step();
        ireq(1'b0, 32'h0);
        bus.m_ack_i = 1'b0;
        settle();
        chk_ctl("fetch_c3_idle", 9'b00_00_00_00_0);

        // ---- contention: fresh reset so last_grant=I, data wins first
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ireq(1'b1, 32'h200);
        dreq(1'b1, 32'h300, 1'b0, 32'h0, 4'hF);
        settle();
        chk_ctl("cont_idle0", 9'b00_00_00_00_0);
        step();
        chk_ctl("cont_d_grant", 9'b10_11_00_00_0);
        chk32("cont_d_adr", bus.m_adr_o, 32'h300);
        bus.m_ack_i = 1'b1;
        settle();
        chk_ctl("cont_d_ack", 9'b10_11_00_10_0);
        step();
        // dwb immediately issues another request: both pending in this IDLE
        bus.m_ack_i = 1'b0;
        dreq(1'b1, 32'h304, 1'b0, 32'h0, 4'hF);
        settle();
        chk_ctl("cont_idle1", 9'b00_00_00_00_0);
        step();
        chk_ctl("cont_i_grant", 9'b01_11_00_00_0);
        chk32("cont_i_adr", bus.m_adr_o, 32'h200);
        bus.m_ack_i = 1'b1;
        settle();
        chk_ctl("cont_i_ack", 9'b01_11_10_00_0);
        step();
        ireq(1'b0, 32'h0);
        bus.m_ack_i = 1'b0;
        settle();
        chk_ctl("cont_idle2", 9'b00_00_00_00_0);
        step();
        chk_ctl("cont_d2_grant", 9'b10_11_00_00_0);
        chk32("cont_d2_adr", bus.m_adr_o, 32'h304);
        bus.m_ack_i = 1'b1;
        settle();
        chk_ctl("cont_d2_ack", 9'b10_11_00_10_0);
        step();
        dreq(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        bus.m_ack_i = 1'b0;
        settle();
        chk_ctl("cont_done", 9'b00_00_00_00_0);

        // ---- masked write to tohost
        dreq(1'b1, 32'h1000, 1'b1, 32'h1, 4'b0001);
        step();
        chk_ctl("wr_grant", 9'b10_11_00_00_0);
        chk32("wr_adr", bus.m_adr_o, 32'h1000);
        chk32("wr_dat", bus.m_dat_o, 32'h1);
        chk32("wr_wesel", {27'h0, bus.m_we_o, bus.m_sel_o}, {27'h0, 5'b1_0001});
        bus.m_ack_i = 1'b1;
        settle();
        chk_ctl("wr_ack", 9'b10_11_00_10_0);
        step();
        dreq(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        bus.m_ack_i = 1'b0;
        settle();
        chk_ctl("wr_done", 9'b00_00_00_00_0);

        // ---- error pass-through
        dreq(1'b1, 32'h2000, 1'b0, 32'h0, 4'hF);
        step();
        bus.m_err_i = 1'b1;
        settle();
        chk_ctl("err_pass", 9'b10_11_00_01_0);
        step();
        dreq(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        bus.m_err_i = 1'b0;
        settle();
        chk_ctl("err_done", 9'b00_00_00_00_0);

        // ---- abort: iwb drops cyc in BUSY cycle 2
        ireq(1'b1, 32'h400);
        step();
        chk_ctl("abort_c1", 9'b01_11_00_00_0);
        step();
        ireq(1'b0, 32'h0);
        settle();
        chk_ctl("abort_c2", 9'b01_00_00_00_0);
        step();
        chk_ctl("abort_idle", 9'b00_00_00_00_0);

        // ---- watchdog boundary: ack lands in BUSY cycle 8
        dreq(1'b1, 32'h500, 1'b0, 32'h0, 4'hF);
        step();
        for (int k = 2; k <= 7; k++) step();
        chk_ctl("wdack_c7", 9'b10_11_00_00_0);
        step();
        bus.m_ack_i = 1'b1;
        settle();
        chk_ctl("wdack_c8", 9'b10_11_00_10_0);
        step();
        dreq(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        bus.m_ack_i = 1'b0;
        settle();
        chk_ctl("wdack_done", 9'b00_00_00_00_0);

        // ---- watchdog fires: memory never responds
        dreq(1'b1, 32'h600, 1'b0, 32'h0, 4'hF);
        step();
        for (int k = 2; k <= 7; k++) step();
        chk_ctl("wd_c7", 9'b10_11_00_00_0);
        step();
        chk_ctl("wd_c8_fire", 9'b10_00_00_01_0);
        step();
        dreq(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        settle();
        chk_ctl("wd_sticky1", 9'b00_00_00_00_1);
        step();
        chk_ctl("wd_sticky2", 9'b00_00_00_00_1);

        // ---- reset mid-transaction clears everything
        dreq(1'b1, 32'h700, 1'b0, 32'h0, 4'hF);
        step();
        chk_ctl("rst_busy", 9'b10_11_00_00_1);
        rst_n = 1'b0;
        step();
        chk_ctl("rst_mid", 9'b00_00_00_00_0);
        chk32("rst_madr", bus.m_adr_o, 32'h0);
        rst_n = 1'b1;
        dreq(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        step();
        chk_ctl("rst_after", 9'b00_00_00_00_0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Two-master Wishbone (classic) arbiter that shares the single unified-memory slave port between the core's instruction bus (iwb) and data bus (dwb). It sits between `custom_riscv_core` and the unified code/data memory, so self-modifying code and FENCE.I see one coherent memory. It uses round-robin arbitration under contention, holds the grant for a full transaction, and runs a per-transaction watchdog that terminates hung cycles with an error.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles without ack/err before a watchdog error is raised. Legal range is 2..65535.
- CNT_W, 16: watchdog counter width. It must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- iwb_adr_i  in  32  instruction address
- iwb_cyc_i, iwb_stb_i  in  1  instruction cycle/strobe
- iwb_dat_o  out  32  read data, = m_dat_i
- iwb_ack_o, iwb_err_o  out  1  instruction ack/error
- dwb_adr_i, dwb_dat_i  in  32  data address / write data
- dwb_we_i  in  1  write enable
- dwb_sel_i  in  4  byte lanes
- dwb_cyc_i, dwb_stb_i  in  1  data cycle/strobe
- dwb_dat_o  out  32  read data, = m_dat_i
- dwb_ack_o, dwb_err_o  out  1  data ack/error
- m_adr_o, m_dat_o  out  32  to memory
- m_we_o  out  1; m_sel_o  out  4; m_cyc_o, m_stb_o  out  1
- m_dat_i  in  32; m_ack_i, m_err_i  in  1
- grant_o  out  2  {d_granted, i_granted}, debug
- timeout_o  out  1  sticky watchdog-fired flag

## Operation
- States: IDLE, BUSY_I, BUSY_D. State, last_grant, counter and timeout_o are registered. Slave-side outputs are a combinational mux of the granted master.
- IDLE: request = cyc_i & stb_i.
  - Only one master requesting → grant it.
  - Both requesting → grant the master not equal to last_grant.
  - last_grant resets to I, so data wins the first contention.
  - On grant, last_grant ← granted master and counter ← 0.
- BUSY_x: m_adr_o/m_dat_o/m_we_o/m_sel_o/m_cyc_o/m_stb_o follow master x (the iwb path drives m_we_o=0, m_sel_o=4'hF, m_dat_o=0). m_cyc_o = x_cyc_i & ~wd_fire.
- Termination in BUSY_x (priority order, first match wins):
  1. m_ack_i=1 → x_ack_o=1 same cycle; next state IDLE.
  2. m_err_i=1 → x_err_o=1 same cycle; next state IDLE.
  3. x_cyc_i=0 (abort) → next state IDLE, no ack/err.
  4. counter == TIMEOUT_CYCLES-1 → wd_fire:
     - x_err_o=1.
     - m_cyc_o=m_stb_o=0 that cycle.
     - timeout_o ← 1.
     - next state IDLE.
  5. Otherwise → counter+1, stay BUSY_x.
- Non-granted master always sees ack_o=err_o=0. Both dat_o ports carry m_dat_i; masters qualify data with ack.
- In IDLE, every m_* output is 0 and every ack/err is 0.
- timeout_o clears only on reset.
- Writes pass dwb_sel_i unchanged. The arbiter performs no byte merging; the memory applies the masked write.

## Timing
- Reset (rst_n=0 at an edge):
  - state IDLE, last_grant=I, counter=0, timeout_o=0.
  - All outputs 0 except dat_o, which follows m_dat_i.
  - Reset asserted mid-transaction drops m_cyc_o after that edge. No ack/err is emitted.
- Arbitration latency: a request seen in IDLE at edge N gives m_cyc_o=1 from N+1.
- Ack/err pass-through: combinational, zero cycles.
- After termination there is always exactly one IDLE cycle, so the same master is never re-granted during its ack cycle. Minimum cycles per transaction = 2 + memory latency.
- Watchdog: with no response, x_err_o pulses in the TIMEOUT_CYCLES-th BUSY cycle.
- Ack and watchdog expiry in the same cycle: ack wins, no err, timeout_o unchanged.
- Request arriving while the other master is BUSY: it waits and is granted at the first IDLE edge after termination.

## Test plan
- Single instruction fetch:
  - Stimulus: iwb cyc/stb to 0x100; memory acks one cycle after m_stb_o with 0x00000013.
  - Required: grant_o=01 from cycle 1; iwb_ack_o=1 with iwb_dat_o=0x00000013 in cycle 2; IDLE in cycle 3; dwb_ack_o never high.
- Contention round-robin:
  - Stimulus: iwb and dwb both request on the same edge after reset, both held until acked.
  - Required: dwb served first, then iwb after one IDLE cycle. A repeated simultaneous pair then serves iwb first.
- Masked write:
  - Stimulus: dwb write to 0x1000 (tohost), data 0x00000001, sel 4'b0001.
  - Required: m_we_o=1, m_sel_o=0001, m_adr_o=0x1000, m_dat_o=1 while granted; dwb_ack_o on memory ack.
- Watchdog (TIMEOUT_CYCLES=8):
  - Stimulus: memory never acks.
  - Required: dwb_err_o pulses in BUSY cycle 8 with m_cyc_o=0 that cycle; timeout_o=1 and stays set.
  - Ack variant: ack in cycle 8 gives ack and no err.
- Abort and reset:
  - Stimulus: iwb drops cyc in BUSY cycle 2 → required: m_cyc_o=0 the same cycle, IDLE next, no ack.
  - Stimulus: rst_n=0 for one edge mid-dwb-transaction → required: all outputs 0 and timeout_o=0 after that edge.
- Error pass-through:
  - Stimulus: m_err_i=1 during a dwb read.
  - Required: dwb_err_o=1 same cycle, dwb_ack_o=0, timeout_o stays 0.
